register_file_2r1w: RTL and testbench

Parametrised register file for the datapath. It has one synchronous write port, two independently enabled read ports with registered outputs, and write-to-read bypass. A sequenced bulk-clear engine clears every entry without a global reset. It replaces the 16x8 single-port register unit and feeds both ALU operands in one cycle.

---
 rtl/register_file_2r1w.sv | 166 ++++++++++++++++
 tb/tb_register_file_2r1w.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/register_file_2r1w.sv
// Two-read, one-write register file with registered read ports, write-first
// bypass and a sequenced bulk-clear engine that zeroes one entry per cycle.

module register_file_2r1w_rd_port #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int ZERO_REG   = 0
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                re,
    input  logic [ADDR_WIDTH-1:0]               raddr,
    input  logic [DEPTH-1:0][DATA_WIDTH-1:0]    mem,
    input  logic                                clr_busy,
    input  logic                                wr_acc,
    input  logic [ADDR_WIDTH-1:0]               waddr,
    input  logic [DATA_WIDTH-1:0]               wdata,
    output logic [DATA_WIDTH-1:0]               rdata
);
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  in_range;
    logic                  zero_hit;

    assign in_range = {1'b0, raddr} < DEPTH_W;
    assign zero_hit = (ZERO_REG != 0) && (raddr == '0);

    // Clearing reads as zero regardless of clear progress, and never bypasses.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            if (clr_busy || !in_range || zero_hit)
                rdata_d = '0;
            else if (wr_acc && (waddr == raddr))
                rdata_d = wdata;
            else
                rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) rdata_q <= '0;
        else       rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
endmodule

module register_file_2r1w #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int ZERO_REG   = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re_a,
    input  logic [ADDR_WIDTH-1:0] raddr_a,
    output logic [DATA_WIDTH-1:0] rdata_a,
    input  logic                  re_b,
    input  logic [ADDR_WIDTH-1:0] raddr_b,
    output logic [DATA_WIDTH-1:0] rdata_b,
    input  logic                  clr_req,
    output logic                  clr_busy
);
    localparam int            NUM_RD  = 2;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_e;

    state_e                          state_q, state_d;
    logic [ADDR_WIDTH-1:0]           clr_idx_q, clr_idx_d;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
    logic                            wr_acc;

    logic [NUM_RD-1:0]                 re_v;
    logic [NUM_RD-1:0][ADDR_WIDTH-1:0] raddr_v;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0] rdata_v;

    // A clear request in the same cycle takes priority over the write.
    assign wr_acc = we && (state_q == IDLE) && !clr_req
                 && ({1'b0, waddr} < DEPTH_W)
                 && !((ZERO_REG != 0) && (waddr == '0));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            IDLE: begin
                clr_idx_d = '0;
                if (clr_req) state_d = CLEAR;
            end
            CLEAR: begin
                if (clr_idx_q == LAST) begin
                    state_d   = IDLE;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                clr_idx_d = '0;
            end
        endcase
    end

    always_comb begin
        clr_busy = (state_q == CLEAR);
    end

    always_comb begin
        mem_d = mem_q;
        if (state_q == CLEAR)
            mem_d[clr_idx_q] = '0;
        else if (wr_acc)
            mem_d[waddr] = wdata;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) mem_q <= '0;
        else       mem_q <= mem_d;
    end

    assign re_v    = {re_b, re_a};
    assign raddr_v = {raddr_b, raddr_a};

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        register_file_2r1w_rd_port #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (DEPTH),
            .ADDR_WIDTH(ADDR_WIDTH),
            .ZERO_REG  (ZERO_REG)
        ) u_rd (
            .clock   (clock),
            .reset   (reset),
            .re      (re_v[p]),
            .raddr   (raddr_v[p]),
            .mem     (mem_q),
            .clr_busy(clr_busy),
            .wr_acc  (wr_acc),
            .waddr   (waddr),
            .wdata   (wdata),
            .rdata   (rdata_v[p])
        );
    end

    assign rdata_a = rdata_v[0];
    assign rdata_b = rdata_v[1];
endmodule

// File: tb/tb_register_file_2r1w.sv
// Bench for register_file_2r1w: a default 16x8 instance and a ZERO_REG=1,
// DEPTH=12 instance share one input bus; expectations go through a queue.

module tb_register_file_2r1w;
    logic       clock = 1'b0;
    logic       reset;
    logic       we, re_a, re_b, clr_req;
    logic [3:0] waddr, raddr_a, raddr_b;
    logic [7:0] wdata;
    logic [7:0] rdata_a0, rdata_b0, rdata_a1, rdata_b1;
    logic       clr_busy0, clr_busy1;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    register_file_2r1w dut0 (
        .clock(clock), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a0),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b0),
        .clr_req(clr_req), .clr_busy(clr_busy0)
    );

    register_file_2r1w #(.DATA_WIDTH(8), .DEPTH(12), .ADDR_WIDTH(4), .ZERO_REG(1)) dut1 (
        .clock(clock), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a1),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b1),
        .clr_req(clr_req), .clr_busy(clr_busy1)
    );

    typedef struct {
        string      name;
        logic       sel;
        logic       we;
        logic [3:0] waddr;
        logic [7:0] wdata;
        logic       re_a;
        logic [3:0] raddr_a;
        logic       re_b;
        logic [3:0] raddr_b;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
    } vec_t;

    typedef struct {
        string      name;
        logic       sel;
        logic [7:0] a;
        logic [7:0] b;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle, queue its expectation, compare after the edge.
    task automatic drive(input vec_t v);
        exp_t e;
        we = v.we; waddr = v.waddr; wdata = v.wdata;
        re_a = v.re_a; raddr_a = v.raddr_a;
        re_b = v.re_b; raddr_b = v.raddr_b;
        clr_req = 1'b0;
        sb.push_back('{v.name, v.sel, v.exp_a, v.exp_b});
        @(posedge clock);
        #1;
        e = sb.pop_front();
        if (e.sel) begin
            chk({e.name, ".a1"}, {24'd0, rdata_a1}, {24'd0, e.a});
            chk({e.name, ".b1"}, {24'd0, rdata_b1}, {24'd0, e.b});
        end else begin
            chk({e.name, ".a0"}, {24'd0, rdata_a0}, {24'd0, e.a});
            chk({e.name, ".b0"}, {24'd0, rdata_b0}, {24'd0, e.b});
        end
        we = 1'b0; re_a = 1'b0; re_b = 1'b0;
    endtask

    task automatic read_all0(input string name);
        for (int i = 0; i < 16; i++)
            drive('{name, 1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'(i), 1'b1, 4'(15 - i), 8'h00, 8'h00});
    endtask

    task automatic pulse_clr();
        we = 1'b0; re_a = 1'b0; re_b = 1'b0; clr_req = 1'b1;
        @(posedge clock);
        #1;
        clr_req = 1'b0;
    endtask

    vec_t main_tbl[9];
    vec_t zr_tbl[7];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        main_tbl[0] = '{"wr3",      0, 1, 4'd3,  8'hA5, 0, 4'd0,  0, 4'd0,  8'h00, 8'h00};
        main_tbl[1] = '{"wr9",      0, 1, 4'd9,  8'h3C, 0, 4'd0,  0, 4'd0,  8'h00, 8'h00};
        main_tbl[2] = '{"rd3_9",    0, 0, 4'd0,  8'h00, 1, 4'd3,  1, 4'd9,  8'hA5, 8'h3C};
        main_tbl[3] = '{"hold_a",   0, 0, 4'd0,  8'h00, 0, 4'd9,  1, 4'd3,  8'hA5, 8'hA5};
        main_tbl[4] = '{"wr5",      0, 1, 4'd5,  8'h11, 0, 4'd0,  0, 4'd0,  8'hA5, 8'hA5};
        main_tbl[5] = '{"bypass5",  0, 1, 4'd5,  8'h77, 1, 4'd5,  1, 4'd5,  8'h77, 8'h77};
        main_tbl[6] = '{"reread5",  0, 0, 4'd0,  8'h00, 1, 4'd5,  1, 4'd9,  8'h77, 8'h3C};
        main_tbl[7] = '{"rd0_15",   0, 0, 4'd0,  8'h00, 1, 4'd0,  1, 4'd15, 8'h00, 8'h00};
        main_tbl[8] = '{"hold_b",   0, 0, 4'd0,  8'h00, 1, 4'd3,  0, 4'd5,  8'hA5, 8'h00};

        zr_tbl[0] = '{"zr_wr0",     1, 1, 4'd0,  8'h99, 0, 4'd0,  0, 4'd0,  8'h5A, 8'h5A};
        zr_tbl[1] = '{"zr_rd0",     1, 0, 4'd0,  8'h00, 1, 4'd0,  1, 4'd0,  8'h00, 8'h00};
        zr_tbl[2] = '{"zr_wr13",    1, 1, 4'd13, 8'h88, 1, 4'd13, 1, 4'd2,  8'h00, 8'h5A};
        zr_tbl[3] = '{"zr_rd13",    1, 0, 4'd0,  8'h00, 1, 4'd13, 1, 4'd11, 8'h00, 8'h00};
        zr_tbl[4] = '{"zr_byp11",   1, 1, 4'd11, 8'h66, 1, 4'd0,  1, 4'd11, 8'h00, 8'h66};
        zr_tbl[5] = '{"zr_rd11",    1, 0, 4'd0,  8'h00, 1, 4'd11, 0, 4'd0,  8'h66, 8'h66};
        zr_tbl[6] = '{"zr_byp0",    1, 1, 4'd0,  8'h99, 1, 4'd0,  1, 4'd11, 8'h00, 8'h66};

        // Reset visible before any clock edge.
        reset = 1'b1; we = 0; re_a = 0; re_b = 0; clr_req = 0;
        waddr = 0; wdata = 0; raddr_a = 0; raddr_b = 0;
        #1;
        chk("rst_a", {24'd0, rdata_a0}, 32'd0);
        chk("rst_b", {24'd0, rdata_b0}, 32'd0);
        chk("rst_busy", {31'd0, clr_busy0}, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        read_all0("rst_rd");

        foreach (main_tbl[i]) drive(main_tbl[i]);

        // Bulk clear: fill with FF, clear, attempt a write behind the clear index.
        for (int i = 0; i < 16; i++)
            drive('{"fill", 1'b0, 1'b1, 4'(i), 8'hFF, 1'b0, 4'd0, 1'b0, 4'd0, 8'hA5, 8'h00});
        pulse_clr();
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("busy%0d", k), {31'd0, clr_busy0}, 32'd1);
            drive('{$sformatf("clr_rd%0d", k), 1'b0, (k == 10), 4'd7, 8'h42,
                    1'b1, 4'd15, 1'b1, 4'(k), 8'h00, 8'h00});
        end
        chk("busy_done", {31'd0, clr_busy0}, 32'd0);
        read_all0("clr_rd_all");

        // Reset in the middle of a clear.
        drive('{"wr12", 1'b0, 1'b1, 4'd12, 8'hFF, 1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 8'h00});
        drive('{"rd12", 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd12, 1'b1, 4'd12, 8'hFF, 8'hFF});
        pulse_clr();
        repeat (6) @(posedge clock);
        #1;
        chk("mid_busy", {31'd0, clr_busy0}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, clr_busy0}, 32'd0);
        chk("mid_rst_a", {24'd0, rdata_a0}, 32'd0);
        chk("mid_rst_b", {24'd0, rdata_b0}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        read_all0("mid_rd_all");
        drive('{"wr2", 1'b0, 1'b1, 4'd2, 8'h5A, 1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 8'h00});
        drive('{"rd2", 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd2, 1'b1, 4'd2, 8'h5A, 8'h5A});
        chk("idle_after", {31'd0, clr_busy0}, 32'd0);

        foreach (zr_tbl[i]) drive(zr_tbl[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
